// File: rtl/uart_receiver_if.sv
// Serial-side bundle for uart_receiver: line/tick inputs and the received word outputs.
// parity_error exists only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            framing_error;
`ifdef UART_RX_PARITY_EN
    logic            parity_error;
`endif

    // master drives the line and the baud tick, slave is the receiver itself
    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  framing_error
`ifdef UART_RX_PARITY_EN
        , input parity_error
`endif
    );

    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output framing_error
`ifdef UART_RX_PARITY_EN
        , output parity_error
`endif
    );
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver with 2-flop rx synchronizer, framing check and
// optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_receiver_if.slave bus
);
    // The tick counter must reach SB_TICK-1, so it widens beyond 4 bits for 1.5/2 stop bits.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            fe_q, fe_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_sync_q, rx_sync_d;
`ifdef UART_RX_PARITY_EN
    logic            pbit_q, pbit_d;
    logic            pe_q, pe_d;
`endif

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        fe_d      = fe_q;
        rx_meta_d = bus.rx;
        rx_sync_d = rx_meta_q;
`ifdef UART_RX_PARITY_EN
        pbit_d    = pbit_q;
        pe_d      = pe_q;
`endif

        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            // Re-check the line at mid start bit so short glitches are rejected.
            START: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_sync_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        pbit_d  = rx_sync_q;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        dout_d  = b_q;
                        fe_d    = ~rx_sync_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        pe_d    = ^{b_q, pbit_q};
`endif
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            fe_q      <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            pbit_q    <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            fe_q      <= fe_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
`ifdef UART_RX_PARITY_EN
            pbit_q    <= pbit_d;
            pe_q      <= pe_d;
`endif
        end
    end

    assign bus.dout          = dout_q;
    assign bus.rx_done_tick  = done_q;
    assign bus.framing_error = fe_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error  = pe_q;
`endif

endmodule
